inst_fetch_seq: RTL
===================

Name: inst_fetch_seq

Overview:
- Parametrised next-generation program counter for the CSE141L core. Generates the instruction-memory line number each cycle.
- Adds to the basic counter:
  - a per-program start address;
  - signed relative and absolute jumps;
  - a hardware call/return stack;
  - an explicit halt/done handshake for the test harness.
- Sits between the decoder/ALU flag outputs and the instruction ROM address input.

Parameters:
- PC_W, 11: width of ProgCtr and of all stored addresses.
- TGT_W, 8: width of the Target field.
- STK_D, 4: return-stack depth in entries (1..16).

Ports:
- Clk  in  1: system clock. All state changes occur on the rising edge only.
- Reset  in  1: synchronous, active-low reset. Sampled on the rising edge of Clk while low.
- Start  in  1: high = load and hold at ProgBase. Falling edge releases execution.
- ProgBase  in  PC_W: start address of the selected program. Sampled while Start is high.
- BranchEn  in  1: conditional branch request.
- ALU_flag  in  1: branch condition from the ALU.
- AbsMode  in  1: target mode for taken branch or call. 1 = absolute (Target zero-extended). 0 = relative (Target sign-extended and added to ProgCtr).
- Target  in  TGT_W: jump offset or address.
- CallEn  in  1: unconditional call. Pushes the return address, then jumps to the target.
- RetEn  in  1: return. Pops the top of stack into ProgCtr.
- HaltEn  in  1: halt instruction.
- ProgCtr  out  PC_W: current instruction address (register).
- Running  out  1: high in RUN state.
- Done  out  1: high in HALT state. Held until the next Start.
- StackErr  out  1: sticky. Set on stack overflow or underflow; cleared only by Reset low or Start high.

Behaviour:
- Reset (Reset=0 at an edge):
  - ProgCtr=0, Running=0, Done=0, StackErr=0.
  - Stack pointer=0 (empty).
  - State=IDLE.
  - Reset overrides every other input in every state, including mid-call and mid-halt.
- States: IDLE, LOAD, RUN, HALT. One-hot or binary encoding is allowed; the outputs are registered.
- IDLE: ProgCtr holds. Start=1 -> LOAD.
- Start=1 in any state (Reset=1):
  - next state LOAD;
  - ProgCtr<=ProgBase, re-sampled every cycle Start is high;
  - stack pointer<=0, StackErr<=0, Done<=0, Running<=0.
- LOAD with Start=0 -> RUN.
  - ProgCtr keeps the last loaded ProgBase.
  - The first RUN cycle presents ProgBase to the ROM, so no address is skipped.
- RUN, per-cycle priority (highest first):
  1. HaltEn: -> HALT. ProgCtr holds.
  2. RetEn:
     - stack empty: StackErr<=1, -> HALT, ProgCtr holds;
     - otherwise: ProgCtr<=top entry, pointer decrements.
  3. CallEn:
     - stack full (STK_D entries): StackErr<=1, -> HALT, ProgCtr holds;
     - otherwise: push ProgCtr+1, ProgCtr<=jump target.
  4. BranchEn && ALU_flag: ProgCtr<=jump target.
  5. Otherwise: ProgCtr<=ProgCtr+1.
- Jump target:
  - AbsMode=1: zero-extended Target.
  - AbsMode=0: ProgCtr + sign-extended Target.
- Arithmetic: all PC arithmetic is modulo 2^PC_W. Increment and relative jumps wrap silently; wrap does not raise an error.
- Simultaneous CallEn and RetEn: RetEn wins and CallEn is ignored, per the priority order.
- The stack holds exactly STK_D entries. The push at depth STK_D-1 succeeds; the next push is an overflow.
- HALT: ProgCtr, stack and StackErr hold. Done=1. Only Start or Reset leaves HALT.
- Running and Done are never high together.

Test Plan:
- Reset then Start:
  - Reset=0 for 2 cycles -> ProgCtr=0 and all flags 0.
  - Start=1 with ProgBase=0x100 for 3 cycles, then Start=0 -> ProgCtr=0x100 on the first RUN cycle, then 0x101, 0x102.
- Relative branch:
  - at ProgCtr=0x105, BranchEn=1, ALU_flag=1, AbsMode=0, Target=0xFB (-5) -> ProgCtr=0x100;
  - same stimulus with ALU_flag=0 -> ProgCtr=0x106.
- Absolute branch and wrap:
  - AbsMode=1, Target=0x3C taken -> ProgCtr=0x03C;
  - from ProgCtr=0x7FF with no branch -> ProgCtr=0x000, StackErr remains 0.
- Call/return:
  - at ProgCtr=0x010, CallEn=1, AbsMode=1, Target=0x80 -> ProgCtr=0x080;
  - after three increments, RetEn=1 -> ProgCtr=0x011;
  - nested calls to depth 4 followed by 4 returns come back in LIFO order.
- Stack errors:
  - fifth nested call with STK_D=4 -> StackErr=1, Done=1, Running=0, ProgCtr frozen;
  - separately, RetEn on an empty stack -> same response;
  - Start=1 then clears StackErr and Done.
- Priority and mid-operation reset:
  - HaltEn=1 together with CallEn=1 -> HALT with no push;
  - Reset=0 asserted during RUN after two pushes -> ProgCtr=0, IDLE, stack empty, so a subsequent RetEn after restart sets StackErr.

Source files
------------

// File: rtl/inst_fetch_seq.sv
// inst_fetch_seq: program counter sequencer for the instruction ROM.
//
// Produces the instruction-memory line number each cycle. Supports a
// per-program start address, signed relative and absolute jumps, a hardware
// call/return stack, and a halt/done handshake for the test harness.
//
// Ports:
//   Clk       - system clock; all state changes on the rising edge
//   Reset     - synchronous active-low reset
//   Start     - high: load and hold ProgBase; release starts execution
//   ProgBase  - start address, sampled every cycle Start is high
//   BranchEn  - conditional branch request, taken when ALU_flag is high
//   ALU_flag  - branch condition from the ALU
//   AbsMode   - 1: Target zero-extended; 0: ProgCtr + sign-extended Target
//   Target    - jump offset or absolute address
//   CallEn    - push return address, then jump
//   RetEn     - pop top of stack into ProgCtr
//   HaltEn    - halt instruction
//   ProgCtr   - current instruction address (registered)
//   Running   - high in RUN
//   Done      - high in HALT, held until the next Start
//   StackErr  - sticky overflow/underflow flag
module inst_fetch_seq #(
  parameter int unsigned PC_W  = 11,
  parameter int unsigned TGT_W = 8,
  parameter int unsigned STK_D = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  ProgBase,
  input  logic             BranchEn,
  input  logic             ALU_flag,
  input  logic             AbsMode,
  input  logic [TGT_W-1:0] Target,
  input  logic             CallEn,
  input  logic             RetEn,
  input  logic             HaltEn,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic             StackErr
);

  // Pointer needs to represent 0..STK_D inclusive; the index only 0..STK_D-1.
  localparam int unsigned SP_W  = $clog2(STK_D + 1);
  localparam int unsigned IDX_W = (STK_D > 1) ? $clog2(STK_D) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            err_q, err_d;
  logic            run_q, done_q;

  logic [PC_W-1:0] stk_q [STK_D];
  logic            push_en;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jump_tgt;
  logic [IDX_W-1:0] push_idx, pop_idx;
  logic            stk_empty, stk_full;

  assign pc_inc    = pc_q + PC_W'(1);
  // Size cast of a signed operand sign-extends; arithmetic wraps mod 2^PC_W.
  assign jump_tgt  = AbsMode ? PC_W'(Target) : pc_q + PC_W'($signed(Target));
  assign push_idx  = IDX_W'(sp_q);
  assign pop_idx   = IDX_W'(sp_q - SP_W'(1));
  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SP_W'(STK_D));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (Start) begin
      state_d = StLoad;
      pc_d    = ProgBase;
      sp_d    = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        // ProgCtr already holds ProgBase, so the first RUN cycle fetches it.
        StLoad: state_d = StRun;
        StRun: begin
          if (HaltEn) begin
            state_d = StHalt;
          end else if (RetEn) begin
            if (stk_empty) begin
              err_d   = 1'b1;
              state_d = StHalt;
            end else begin
              pc_d = stk_q[pop_idx];
              sp_d = sp_q - SP_W'(1);
            end
          end else if (CallEn) begin
            if (stk_full) begin
              err_d   = 1'b1;
              state_d = StHalt;
            end else begin
              push_en = 1'b1;
              pc_d    = jump_tgt;
              sp_d    = sp_q + SP_W'(1);
            end
          end else if (BranchEn && ALU_flag) begin
            pc_d = jump_tgt;
          end else begin
            pc_d = pc_inc;
          end
        end
        StHalt: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      run_q   <= (state_d == StRun);
      done_q  <= (state_d == StHalt);
    end
  end

  // Stack storage needs no reset: the pointer alone defines valid entries.
  always_ff @(posedge Clk) begin
    if (Reset && push_en) begin
      stk_q[push_idx] <= pc_inc;
    end
  end

  assign ProgCtr  = pc_q;
  assign Running  = run_q;
  assign Done     = done_q;
  assign StackErr = err_q;

endmodule
